// File: rtl/otf_converter.sv
// On-the-fly converter: MSB-first borrow-save signed digits to an (N+1)-bit two's-complement result via the Q/QM recurrence.
// Optional macro OTF_QM_OUT_EN adds qm_out (final QM, equal to q_out - 1).
module otf_converter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         in_first,
    input  logic         zp,
    input  logic         zn,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
`ifdef OTF_QM_OUT_EN
    output logic [N:0]   qm_out,
`endif
    output logic [N:0]   q_out
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t          state_q, state_d;
    logic [N:0]      q_q, q_d;
    logic [N:0]      qm_q, qm_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N:0]      qout_q, qout_d;
    logic [N:0]      qmout_q, qmout_d;

    logic            accept;
    logic            start;
    logic            d_pos;
    logic            d_neg;
    logic [N:0]      q_base, qm_base;
    logic [N:0]      q_step, qm_step;
    logic [CW-1:0]   cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            qm_q    <= '1;
            cnt_q   <= '0;
            qout_q  <= '0;
            qmout_q <= '1;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            qm_q    <= qm_d;
            cnt_q   <= cnt_d;
            qout_q  <= qout_d;
            qmout_q <= qmout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        qm_d    = qm_q;
        cnt_d   = cnt_q;
        qout_d  = qout_q;
        qmout_d = qmout_q;

        in_ready  = (state_q != DONE);
        out_valid = (state_q == DONE);
        busy      = (state_q == CONV);

        accept = in_valid && in_ready;
        start  = accept && ((state_q == IDLE) || in_first);

        // 11 and 00 both decode to zero
        d_pos = zp && !zn;
        d_neg = zn && !zp;

        q_base  = start ? '0 : q_q;
        qm_base = start ? '1 : qm_q;

        if (d_pos) begin
            q_step  = {q_base[N-1:0], 1'b1};
            qm_step = {q_base[N-1:0], 1'b0};
        end else if (d_neg) begin
            q_step  = {qm_base[N-1:0], 1'b1};
            qm_step = {qm_base[N-1:0], 1'b0};
        end else begin
            q_step  = {q_base[N-1:0], 1'b0};
            qm_step = {qm_base[N-1:0], 1'b1};
        end

        cnt_nxt = start ? CW'(1) : cnt_q + CW'(1);

        if (accept) begin
            q_d   = q_step;
            qm_d  = qm_step;
            cnt_d = cnt_nxt;
            if (cnt_nxt == CNT_LAST) begin
                state_d = DONE;
                qout_d  = q_step;
                qmout_d = qm_step;
            end else begin
                state_d = CONV;
            end
        end

        if ((state_q == DONE) && out_ready) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    assign q_out = qout_q;
`ifdef OTF_QM_OUT_EN
    assign qm_out = qmout_q;
`endif

endmodule

// File: tb/tb_otf_converter.sv
// Directed bench for otf_converter at N=4; expected results worked out by hand from sum d_i*2^(4-i).
module tb_otf_converter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_first = 1'b0;
    logic         zp = 1'b0;
    logic         zn = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         busy;
    logic [N:0]   q_out;
`ifdef OTF_QM_OUT_EN
    logic [N:0]   qm_out;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    otf_converter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .zp        (zp),
        .zn        (zn),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
`ifdef OTF_QM_OUT_EN
        .qm_out    (qm_out),
`endif
        .q_out     (q_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1ns after the rising edge.
    task automatic step(input logic v, input logic f, input logic p, input logic n, input logic r);
        in_valid  = v;
        in_first  = f;
        zp        = p;
        zn        = n;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic dig(input int d, input logic f, input logic r);
        if (d > 0)      step(1'b1, f, 1'b1, 1'b0, r);
        else if (d < 0) step(1'b1, f, 1'b0, 1'b1, r);
        else            step(1'b1, f, 1'b0, 1'b0, r);
    endtask

    initial begin
        // Reset
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0, 0, 0);
        chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_busy",      {7'd0, busy},      8'd0);
        chk("rst_in_ready",  {7'd0, in_ready},  8'd1);
        chk("rst_q_out",     {3'd0, q_out},     8'h00);
`ifdef OTF_QM_OUT_EN
        chk("rst_qm_out",    {3'd0, qm_out},    8'h1F);
`endif

        // +1,0,-1,+1 -> 7, out_ready high
        dig(1, 1, 1);
        chk("t1_busy1", {7'd0, busy}, 8'd1);
        dig(0, 0, 1);
        chk("t1_busy2", {7'd0, busy}, 8'd1);
        dig(-1, 0, 1);
        chk("t1_busy3", {7'd0, busy}, 8'd1);
        chk("t1_early_valid", {7'd0, out_valid}, 8'd0);
        dig(1, 0, 1);
        chk("t1_out_valid", {7'd0, out_valid}, 8'd1);
        chk("t1_q_out",     {3'd0, q_out},     8'h07);
        chk("t1_busy_done", {7'd0, busy},      8'd0);
        chk("t1_in_ready",  {7'd0, in_ready},  8'd0);
`ifdef OTF_QM_OUT_EN
        chk("t1_qm_out",    {3'd0, qm_out},    8'h06);
`endif
        step(0, 0, 0, 0, 1);
        chk("t1_idle_valid", {7'd0, out_valid}, 8'd0);
        chk("t1_idle_ready", {7'd0, in_ready},  8'd1);
        chk("t1_q_hold",     {3'd0, q_out},     8'h07);

        // Four -1 digits -> -15, then backpressure with in_valid held high
        dig(-1, 1, 0);
        dig(-1, 0, 0);
        dig(-1, 0, 0);
        dig(-1, 0, 0);
        chk("t2_q_out", {3'd0, q_out}, 8'h11);
        for (int i = 0; i < 5; i++) begin
            dig(1, 0, 0);
            chk("bp_valid",    {7'd0, out_valid}, 8'd1);
            chk("bp_q_out",    {3'd0, q_out},     8'h11);
            chk("bp_in_ready", {7'd0, in_ready},  8'd0);
        end
        step(0, 0, 0, 0, 1);
        chk("bp_release_valid", {7'd0, out_valid}, 8'd0);
        chk("bp_release_ready", {7'd0, in_ready},  8'd1);
        chk("bp_release_busy",  {7'd0, busy},      8'd0);

        // Four +1 digits -> 15
        dig(1, 1, 1);
        dig(1, 0, 1);
        dig(1, 0, 1);
        dig(1, 0, 1);
        chk("t3_valid", {7'd0, out_valid}, 8'd1);
        chk("t3_q_out", {3'd0, q_out},     8'h0F);
        step(0, 0, 0, 0, 1);

        // Four zeros, one encoded as zp=zn=1, first flag absent in IDLE
        dig(0, 0, 1);
        step(1, 0, 1, 1, 1);
        dig(0, 0, 1);
        dig(0, 0, 1);
        chk("t4_valid", {7'd0, out_valid}, 8'd1);
        chk("t4_q_out", {3'd0, q_out},     8'h00);
        step(0, 0, 0, 0, 1);

        // Restart: +1,+1 discarded, then +1,0,0,-1 -> 7
        dig(1, 1, 1);
        dig(1, 0, 1);
        dig(1, 1, 1);
        chk("t5_restart_busy", {7'd0, busy}, 8'd1);
        dig(0, 0, 1);
        dig(0, 0, 1);
        chk("t5_no_early", {7'd0, out_valid}, 8'd0);
        dig(-1, 0, 1);
        chk("t5_valid", {7'd0, out_valid}, 8'd1);
        chk("t5_q_out", {3'd0, q_out},     8'h07);
        step(0, 0, 0, 0, 1);

        // Stalls between digits: +1,0,-1,+1 -> 7
        dig(1, 1, 1);
        step(0, 0, 1, 0, 1);
        chk("t6_stall_busy",  {7'd0, busy},      8'd1);
        dig(0, 0, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 1, 0, 1);
        chk("t6_stall_valid", {7'd0, out_valid}, 8'd0);
        dig(-1, 0, 1);
        step(0, 0, 0, 0, 1);
        dig(1, 0, 1);
        chk("t6_valid", {7'd0, out_valid}, 8'd1);
        chk("t6_q_out", {3'd0, q_out},     8'h07);
        step(0, 0, 0, 0, 1);

        // Reset after two digits aborts; next operand -1,0,0,+1 -> -7
        dig(1, 1, 1);
        dig(1, 0, 1);
        rst = 1'b1;
        dig(1, 0, 1);
        rst = 1'b0;
        step(0, 0, 0, 0, 1);
        chk("t7_rst_valid", {7'd0, out_valid}, 8'd0);
        chk("t7_rst_busy",  {7'd0, busy},      8'd0);
        chk("t7_rst_q_out", {3'd0, q_out},     8'h00);
`ifdef OTF_QM_OUT_EN
        chk("t7_rst_qm_out", {3'd0, qm_out},   8'h1F);
`endif
        dig(-1, 1, 1);
        dig(0, 0, 1);
        dig(0, 0, 1);
        dig(1, 0, 1);
        chk("t7_valid", {7'd0, out_valid}, 8'd1);
        chk("t7_q_out", {3'd0, q_out},     8'h19);
`ifdef OTF_QM_OUT_EN
        chk("t7_qm_out", {3'd0, qm_out},   8'h18);
`endif
        step(0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
